control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired Mini SRC control unit. Sits directly upstream of datapath and generates the per-T-step control strobes.
//  Decodes IR_Data and steps fetch (T0-T2) plus execute (T3-T6) for register-register ALU/shift ops, mul, div and halt.
//  Waits on the memory handshake during instruction fetch.
// PARAMETERS
//  OPCODE_W  5  width of IR[31:27] opcode field, driven onto alu_instruction
//  REGSEL_W  4  width of ra/rb/rc fields (IR[26:23], [22:19], [18:15])
// PORTS
//  clk              in   1  system clock; all state changes on rising edge
//  clr              in   1  one clock; reset is synchronous and active-high
//  IR_Data          in   32 current instruction register contents
//  mem_ready        in   1  memory read data valid on Mdatain this cycle
//  Gra/Grb/Grc      out  1  select ra/rb/rc field for the datapath register select/encode
//  R_in/R_out       out  1  write/drive the register selected by Gra/Grb/Grc
//  PC_out/PC_in     out  1  PC bus drive / load
//  IncPC            out  1  ALU computes PC+1 this cycle
//  MAR_in           out  1  MAR load
//  MDR_in/MDR_out   out  1  MDR load / drive
//  Read             out  1  memory read request
//  IR_in/Y_in/Z_in  out  1  IR, Y, Z loads
//  Zlow_out/Zhigh_out out 1 Z halves bus drive
//  HI_in/LO_in      out  1  HI/LO loads
//  alu_instruction  out  5  ALU op; equals IR_Data[31:27] in ALU T4, else 0
//  run              out  1  high while sequencing, low after halt
//  illegal_op       out  1  one-cycle pulse on unsupported opcode
// BEHAVIOUR
//  State register: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
//  Strobes are a Moore decode of the registered state. They are valid for the full cycle.
//  In RST and HALT every output is 0 except run. run=1 in RST, run=0 in HALT.
//  clr=1 at any edge forces RST, with priority over all else, including mid-T1 or mid-instruction.
//  RST->T0 on the next edge with clr=0. No partial instruction survives reset.
//  T0: PC_out, MAR_in, IncPC, Z_in. Always ->T1.
//  T1: Zlow_out, PC_in, Read, MDR_in.
//    Hold in T1 while mem_ready=0, keeping Read/MDR_in high. PC_in is asserted only in the cycle mem_ready=1.
//    Advance to T2 on mem_ready=1, so PC increments exactly once.
//  T2: MDR_out, IR_in. Always ->T3. Decode in T3 uses the new IR_Data.
//  ALU ops (add, sub, and, or, shr, shra, shl, ror, rol):
//    T3: Grb, R_out, Y_in.
//    T4: Grc, R_out, Z_in, alu_instruction=op.
//    T5: Zlow_out, Gra, R_in. Then ->T0.
//  Unary ops (neg, not):
//    T3: Grb, R_out, Z_in, alu_instruction=op.
//    T4: Zlow_out, Gra, R_in. Then ->T0; T5 is skipped.
//  mul/div:
//    T3: Gra, R_out, Y_in.
//    T4: Grb, R_out, Z_in, alu_instruction=op.
//    T5: Zlow_out, LO_in.
//    T6: Zhigh_out, HI_in. Then ->T0.
//  nop: T3 ->T0 with no strobes.
//  halt: T3 ->HALT. HALT is left only by clr.
//  Unsupported opcode: illegal_op=1 in T3, no other strobes, then ->T0.
//  Per cycle at most one bus driver is high. Driver set: R_out, PC_out, MDR_out, Zlow_out, Zhigh_out.
//  Latency after fetch (T0-T2 plus wait cycles): ALU 6, unary 5, mul/div 7, nop 4 cycles.
// STRUCTURE
//  Shared package minisrc_pkg:
//    opcode localparams (e.g. shl=5'b01001, plus the full op map);
//    state encoding; IR field bit positions.
//  One sub-module, control_decode: combinational opcode -> class (ALU, UNARY, MULDIV, NOP, HALT, ILLEGAL).
//  The FSM and strobe decode stay in control_sequencer.
// TESTING
//  1. clr=1 for 2 cycles, then 0 -> all strobes 0 during clr. run=1. T0 strobes on the first post-reset cycle.
//  2. IR=0x489A8000 (shl R1,R3,R5), mem_ready=1 -> T3 Grb+R_out+Y_in, T4 Grc+R_out+Z_in with alu_instruction=5'b01001, T5 Gra+R_in.
//  3. mem_ready low for 3 cycles in T1 -> T1 held 4 cycles, Read high throughout, PC_in pulsed exactly once.
//  4. mul opcode -> T5 LO_in+Zlow_out, T6 HI_in+Zhigh_out, back to T0 on the 8th cycle.
//  5. halt, then illegal opcode after clr -> run falls and strobes stay 0; illegal_op pulses 1 cycle then T0.
//  6. clr asserted in T4 of shl -> next state RST, R_in never asserted for that instruction.

Source files
------------

// File: rtl/minisrc_pkg.sv
// Shared Mini SRC definitions: opcode map, IR field positions,
// sequencer state encoding and the opcode class used by the decoder.
package minisrc_pkg;

    localparam int OPCODE_W = 5;
    localparam int REGSEL_W = 4;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = RA_MSB - REGSEL_W + 1;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = RB_MSB - REGSEL_W + 1;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = RC_MSB - REGSEL_W + 1;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_LD   = 5'b00000;
    localparam opcode_t OP_LDI  = 5'b00001;
    localparam opcode_t OP_ST   = 5'b00010;
    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110;
    localparam opcode_t OP_SHR  = 5'b00111;
    localparam opcode_t OP_SHRA = 5'b01000;
    localparam opcode_t OP_SHL  = 5'b01001;
    localparam opcode_t OP_ROR  = 5'b01010;
    localparam opcode_t OP_ROL  = 5'b01011;
    localparam opcode_t OP_ADDI = 5'b01100;
    localparam opcode_t OP_ANDI = 5'b01101;
    localparam opcode_t OP_ORI  = 5'b01110;
    localparam opcode_t OP_DIV  = 5'b01111;
    localparam opcode_t OP_MUL  = 5'b10000;
    localparam opcode_t OP_NEG  = 5'b10001;
    localparam opcode_t OP_NOT  = 5'b10010;
    localparam opcode_t OP_BR   = 5'b10011;
    localparam opcode_t OP_JR   = 5'b10100;
    localparam opcode_t OP_JAL  = 5'b10101;
    localparam opcode_t OP_IN   = 5'b10110;
    localparam opcode_t OP_OUT  = 5'b10111;
    localparam opcode_t OP_MFHI = 5'b11000;
    localparam opcode_t OP_MFLO = 5'b11001;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_UNARY, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction/memory status in, control strobes out.
interface control_sequencer_if;
    import minisrc_pkg::*;

    logic [31:0] IR_Data;
    logic        mem_ready;

    logic Gra, Grb, Grc, R_in, R_out;
    logic PC_out, PC_in, IncPC, MAR_in;
    logic MDR_in, MDR_out, Read, IR_in;
    logic Y_in, Z_in, Zlow_out, Zhigh_out, HI_in, LO_in;
    opcode_t alu_instruction;
    logic run, illegal_op;

    modport master (
        input  IR_Data, mem_ready,
        output Gra, Grb, Grc, R_in, R_out, PC_out, PC_in, IncPC, MAR_in,
               MDR_in, MDR_out, Read, IR_in, Y_in, Z_in, Zlow_out, Zhigh_out,
               HI_in, LO_in, alu_instruction, run, illegal_op
    );

    modport slave (
        output IR_Data, mem_ready,
        input  Gra, Grb, Grc, R_in, R_out, PC_out, PC_in, IncPC, MAR_in,
               MDR_in, MDR_out, Read, IR_in, Y_in, Z_in, Zlow_out, Zhigh_out,
               HI_in, LO_in, alu_instruction, run, illegal_op
    );

endinterface

// File: rtl/control_decode.sv
// Combinational opcode classifier; anything not executed by this control unit is ILLEGAL.
module control_decode
    import minisrc_pkg::*;
(
    input  opcode_t   opcode,
    output op_class_t op_class
);

    always_comb begin
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:        op_class = CLS_ALU;
            OP_NEG, OP_NOT:                         op_class = CLS_UNARY;
            OP_MUL, OP_DIV:                         op_class = CLS_MULDIV;
            OP_NOP:                                 op_class = CLS_NOP;
            OP_HALT:                                op_class = CLS_HALT;
            default:                                op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch T0-T2 with memory wait, execute T3-T6,
// strobes decoded from the registered state (PC_in additionally gated by mem_ready).
module control_sequencer
    import minisrc_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr,
    control_sequencer_if.master  bus
);

    state_t    state, state_next;
    opcode_t   opcode;
    op_class_t op_class;

    assign opcode = bus.IR_Data[OP_MSB:OP_LSB];

    control_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // NOTE: non-blocking so the register samples state_next as it was before the edge.
    always_ff @(posedge clk) begin
        if (clr) state <= S_RST;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RST:  state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   if (bus.mem_ready) state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_T3: begin
                case (op_class)
                    CLS_ALU, CLS_UNARY, CLS_MULDIV: state_next = S_T4;
                    CLS_HALT:                       state_next = S_HALT;
                    default:                        state_next = S_T0;
                endcase
            end
            S_T4:   state_next = (op_class == CLS_ALU || op_class == CLS_MULDIV) ? S_T5 : S_T0;
            S_T5:   state_next = (op_class == CLS_MULDIV) ? S_T6 : S_T0;
            S_T6:   state_next = S_T0;
            S_HALT: state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

    // NOTE: every output gets a default first, so no state/class path can infer a latch.
    always_comb begin
        bus.Gra = 1'b0;       bus.Grb = 1'b0;      bus.Grc = 1'b0;
        bus.R_in = 1'b0;      bus.R_out = 1'b0;
        bus.PC_out = 1'b0;    bus.PC_in = 1'b0;    bus.IncPC = 1'b0;
        bus.MAR_in = 1'b0;    bus.MDR_in = 1'b0;   bus.MDR_out = 1'b0;
        bus.Read = 1'b0;      bus.IR_in = 1'b0;
        bus.Y_in = 1'b0;      bus.Z_in = 1'b0;
        bus.Zlow_out = 1'b0;  bus.Zhigh_out = 1'b0;
        bus.HI_in = 1'b0;     bus.LO_in = 1'b0;
        bus.alu_instruction = '0;
        bus.illegal_op = 1'b0;
        bus.run = (state != S_HALT);

        case (state)
            S_T0: begin
                bus.PC_out = 1'b1; bus.MAR_in = 1'b1; bus.IncPC = 1'b1; bus.Z_in = 1'b1;
            end
            S_T1: begin
                // PC reload only in the completing cycle so a stalled fetch bumps PC once.
                bus.Zlow_out = 1'b1; bus.Read = 1'b1; bus.MDR_in = 1'b1;
                bus.PC_in    = bus.mem_ready;
            end
            S_T2: begin
                bus.MDR_out = 1'b1; bus.IR_in = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    CLS_ALU:    begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Y_in = 1'b1; end
                    CLS_UNARY:  begin
                        bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Z_in = 1'b1;
                        bus.alu_instruction = opcode;
                    end
                    CLS_MULDIV: begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.Y_in = 1'b1; end
                    CLS_ILLEGAL: bus.illegal_op = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    CLS_ALU: begin
                        bus.Grc = 1'b1; bus.R_out = 1'b1; bus.Z_in = 1'b1;
                        bus.alu_instruction = opcode;
                    end
                    CLS_UNARY: begin bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                    CLS_MULDIV: begin
                        bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Z_in = 1'b1;
                        bus.alu_instruction = opcode;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    CLS_ALU:    begin bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                    CLS_MULDIV: begin bus.Zlow_out = 1'b1; bus.LO_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                bus.Zhigh_out = 1'b1; bus.HI_in = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed vector table, hand sequences
// for stall/halt/illegal/abort, then random instructions against a step-list model.
module tb_control_sequencer;

    typedef struct packed {
        logic gra, grb, grc, r_in, r_out;
        logic pc_out, pc_in, inc_pc, mar_in;
        logic mdr_in, mdr_out, read, ir_in;
        logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
        logic [4:0] alu;
        logic run, illegal;
    } obs_t;

    typedef struct {
        logic        clr;
        logic        mem_ready;
        logic [31:0] ir;
        obs_t        exp;
    } vec_t;

    localparam logic [31:0] SHL_IR  = 32'h489A_8000;
    localparam logic [31:0] MUL_IR  = 32'h8119_8000;
    localparam logic [31:0] NOP_IR  = 32'hD000_0000;
    localparam logic [31:0] HALT_IR = 32'hD800_0000;
    localparam logic [31:0] ILL_IR  = 32'hE123_4567;

    logic clk = 1'b0;
    logic clr;
    int   tests = 0;
    int   fails = 0;
    int   pc_in_seen = 0;
    obs_t exec_q[$];
    bit   exec_halts;
    vec_t vt[16];

    always #5 clk = ~clk;

    control_sequencer_if bus();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    function automatic obs_t sample();
        obs_t a;
        a.gra = bus.Gra;         a.grb = bus.Grb;         a.grc = bus.Grc;
        a.r_in = bus.R_in;       a.r_out = bus.R_out;
        a.pc_out = bus.PC_out;   a.pc_in = bus.PC_in;     a.inc_pc = bus.IncPC;
        a.mar_in = bus.MAR_in;   a.mdr_in = bus.MDR_in;   a.mdr_out = bus.MDR_out;
        a.read = bus.Read;       a.ir_in = bus.IR_in;
        a.y_in = bus.Y_in;       a.z_in = bus.Z_in;
        a.zlow_out = bus.Zlow_out; a.zhigh_out = bus.Zhigh_out;
        a.hi_in = bus.HI_in;     a.lo_in = bus.LO_in;
        a.alu = bus.alu_instruction;
        a.run = bus.run;         a.illegal = bus.illegal_op;
        return a;
    endfunction

    function automatic obs_t idle();
        obs_t o = '0;
        o.run = 1'b1;
        return o;
    endfunction

    function automatic obs_t fetch_t0();
        obs_t o = idle();
        o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.z_in = 1'b1;
        return o;
    endfunction

    function automatic obs_t fetch_t1(input logic ready);
        obs_t o = idle();
        o.zlow_out = 1'b1; o.read = 1'b1; o.mdr_in = 1'b1; o.pc_in = ready;
        return o;
    endfunction

    function automatic obs_t fetch_t2();
        obs_t o = idle();
        o.mdr_out = 1'b1; o.ir_in = 1'b1;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: compare at the falling edge, return just after the next rising edge.
    task automatic cycle(input obs_t exp, input string name);
        obs_t a;
        @(negedge clk);
        a = sample();
        if (a.pc_in) pc_in_seen++;
        check(name, {6'd0, a}, {6'd0, exp});
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Reference model: the register-transfer steps an instruction performs after fetch.
    task automatic build_exec(input logic [31:0] ir);
        logic [4:0] op;
        obs_t o;
        op = ir[31:27];
        exec_q = {};
        exec_halts = 1'b0;
        if (op inside {[5'd3:5'd11]}) begin
            o = idle(); o.grb = 1; o.r_out = 1; o.y_in = 1;              exec_q.push_back(o);
            o = idle(); o.grc = 1; o.r_out = 1; o.z_in = 1; o.alu = op;  exec_q.push_back(o);
            o = idle(); o.zlow_out = 1; o.gra = 1; o.r_in = 1;           exec_q.push_back(o);
        end else if (op inside {5'd17, 5'd18}) begin
            o = idle(); o.grb = 1; o.r_out = 1; o.z_in = 1; o.alu = op;  exec_q.push_back(o);
            o = idle(); o.zlow_out = 1; o.gra = 1; o.r_in = 1;           exec_q.push_back(o);
        end else if (op inside {5'd15, 5'd16}) begin
            o = idle(); o.gra = 1; o.r_out = 1; o.y_in = 1;              exec_q.push_back(o);
            o = idle(); o.grb = 1; o.r_out = 1; o.z_in = 1; o.alu = op;  exec_q.push_back(o);
            o = idle(); o.zlow_out = 1; o.lo_in = 1;                     exec_q.push_back(o);
            o = idle(); o.zhigh_out = 1; o.hi_in = 1;                    exec_q.push_back(o);
        end else if (op == 5'd26) begin
            exec_q.push_back(idle());
        end else if (op == 5'd27) begin
            exec_q.push_back(idle());
            exec_halts = 1'b1;
        end else begin
            o = idle(); o.illegal = 1;                                   exec_q.push_back(o);
        end
    endtask

    task automatic fetch(input logic [31:0] ir, input int waits, input string tag);
        bus.mem_ready = rnd_bit();
        cycle(fetch_t0(), {tag, " T0"});
        for (int w = 0; w < waits; w++) begin
            bus.mem_ready = 1'b0;
            cycle(fetch_t1(1'b0), {tag, " T1 wait"});
        end
        bus.mem_ready = 1'b1;
        cycle(fetch_t1(1'b1), {tag, " T1 ready"});
        bus.mem_ready = rnd_bit();
        cycle(fetch_t2(), {tag, " T2"});
        bus.IR_Data = ir;
    endtask

    // Plays exec_q; abort_at >= 0 raises clr during that step.
    task automatic run_exec(input int abort_at);
        for (int i = 0; i < exec_q.size(); i++) begin
            bus.mem_ready = rnd_bit();
            if (i == abort_at) begin
                clr = 1'b1;
                cycle(exec_q[i], "rnd step under clr");
                clr = 1'b0;
                cycle(idle(), "rnd RST after abort");
                return;
            end
            cycle(exec_q[i], $sformatf("rnd exec step %0d", i));
        end
        if (exec_halts) begin
            cycle('0, "rnd HALT 1");
            cycle('0, "rnd HALT 2");
            clr = 1'b1;
            cycle('0, "rnd HALT under clr");
            clr = 1'b0;
            cycle(idle(), "rnd RST after halt");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int   pc0;
        int   waits;
        int   abort_at;
        logic [31:0] ir;

        vt[0]  = '{1'b1, 1'b0, SHL_IR, idle()};
        vt[1]  = '{1'b0, 1'b1, SHL_IR, idle()};
        vt[2]  = '{1'b0, 1'b0, SHL_IR, fetch_t0()};
        vt[3]  = '{1'b0, 1'b1, SHL_IR, fetch_t1(1'b1)};
        vt[4]  = '{1'b0, 1'b0, SHL_IR, fetch_t2()};
        o = idle(); o.grb = 1; o.r_out = 1; o.y_in = 1;
        vt[5]  = '{1'b0, 1'b0, SHL_IR, o};
        o = idle(); o.grc = 1; o.r_out = 1; o.z_in = 1; o.alu = 5'b01001;
        vt[6]  = '{1'b0, 1'b1, SHL_IR, o};
        o = idle(); o.zlow_out = 1; o.gra = 1; o.r_in = 1;
        vt[7]  = '{1'b0, 1'b0, SHL_IR, o};
        vt[8]  = '{1'b0, 1'b0, MUL_IR, fetch_t0()};
        vt[9]  = '{1'b0, 1'b1, MUL_IR, fetch_t1(1'b1)};
        vt[10] = '{1'b0, 1'b0, MUL_IR, fetch_t2()};
        o = idle(); o.gra = 1; o.r_out = 1; o.y_in = 1;
        vt[11] = '{1'b0, 1'b1, MUL_IR, o};
        o = idle(); o.grb = 1; o.r_out = 1; o.z_in = 1; o.alu = 5'b10000;
        vt[12] = '{1'b0, 1'b0, MUL_IR, o};
        o = idle(); o.zlow_out = 1; o.lo_in = 1;
        vt[13] = '{1'b0, 1'b1, MUL_IR, o};
        o = idle(); o.zhigh_out = 1; o.hi_in = 1;
        vt[14] = '{1'b0, 1'b0, MUL_IR, o};
        vt[15] = '{1'b0, 1'b0, MUL_IR, fetch_t0()};

        clr = 1'b1;
        bus.mem_ready = 1'b0;
        bus.IR_Data = SHL_IR;
        @(posedge clk);
        #1;

        // Reset, shl and mul walked cycle by cycle.
        for (int i = 0; i < 16; i++) begin
            clr = vt[i].clr;
            bus.mem_ready = vt[i].mem_ready;
            bus.IR_Data = vt[i].ir;
            cycle(vt[i].exp, $sformatf("vec%0d", i));
        end

        // Stalled fetch: T1 held four cycles, PC reloaded once.
        pc0 = pc_in_seen;
        for (int w = 0; w < 3; w++) begin
            bus.mem_ready = 1'b0;
            cycle(fetch_t1(1'b0), "stall T1 wait");
        end
        bus.mem_ready = 1'b1;
        cycle(fetch_t1(1'b1), "stall T1 ready");
        check("stall pc_in pulses", 32'(pc_in_seen - pc0), 32'd1);
        bus.mem_ready = 1'b0;
        cycle(fetch_t2(), "stall T2");
        bus.IR_Data = NOP_IR;
        cycle(idle(), "nop T3");

        // halt, recover with clr, then an unsupported opcode.
        fetch(HALT_IR, 0, "halt");
        cycle(idle(), "halt T3");
        cycle('0, "HALT 1");
        bus.mem_ready = 1'b1;
        cycle('0, "HALT 2");
        clr = 1'b1;
        cycle('0, "HALT under clr");
        clr = 1'b0;
        cycle(idle(), "RST after halt");
        fetch(ILL_IR, 1, "illegal");
        o = idle(); o.illegal = 1;
        cycle(o, "illegal T3");
        cycle(fetch_t0(), "T0 after illegal");

        // clr during T4 of shl: next cycle is RST, no write-back.
        bus.mem_ready = 1'b1;
        cycle(fetch_t1(1'b1), "abort T1");
        cycle(fetch_t2(), "abort T2");
        bus.IR_Data = SHL_IR;
        cycle(vt[5].exp, "abort T3");
        clr = 1'b1;
        cycle(vt[6].exp, "abort T4 under clr");
        clr = 1'b0;
        cycle(idle(), "RST after abort");

        // Random instructions, stalls and occasional mid-execute clr.
        for (int n = 0; n < 150; n++) begin
            ir = $urandom;
            waits = int'($urandom_range(0, 3));
            fetch(ir, waits, "rnd");
            build_exec(ir);
            abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, exec_q.size() - 1)) : -1;
            run_exec(abort_at);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
